// File: rtl/axi_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : axi_read_arbiter
//  Description : Shares one AXI read port (AR/R) between the instruction
//                fetch unit (I-side) and the load unit (D-side). One
//                transaction is outstanding at a time: a request is accepted
//                in IDLE, issued on AR, and its R beats are checked and
//                steered back to the requester that was granted.
//  Revision    : 1.0  initial release
//
//  Configuration macro:
//    ARB_RR_EN  defined   -> round-robin between I and D when both request
//               undefined -> fixed priority, D-side over I-side
//
//  Ports:
//    clk, reset                 clock, asynchronous active-low reset
//    {i,d}_req_valid/ready      request handshake (ready is combinational)
//    {i,d}_req_addr/len/size    request fields (AXI arlen/arsize encoding)
//    {i,d}_rsp_valid/data       one registered beat per R handshake
//    {i,d}_rsp_last/err         last beat / beat error flag
//    m_axi_ar*                  AXI read address channel (master side)
//    m_axi_r*                   AXI read data channel (master side)
// ============================================================================
module axi_read_arbiter #(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  i_req_valid,
    output logic                  i_req_ready,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [7:0]            i_req_len,
    input  logic [2:0]            i_req_size,
    output logic                  i_rsp_valid,
    output logic [DATA_WIDTH-1:0] i_rsp_data,
    output logic                  i_rsp_last,
    output logic                  i_rsp_err,

    input  logic                  d_req_valid,
    output logic                  d_req_ready,
    input  logic [ADDR_WIDTH-1:0] d_req_addr,
    input  logic [7:0]            d_req_len,
    input  logic [2:0]            d_req_size,
    output logic                  d_rsp_valid,
    output logic [DATA_WIDTH-1:0] d_rsp_data,
    output logic                  d_rsp_last,
    output logic                  d_rsp_err,

    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;

    logic                  grant;          // 0 = I-side, 1 = D-side
    logic                  pick_d;         // arbitration result in IDLE
    logic                  accept;
    logic                  beat;
    logic                  beat_err;
    logic [7:0]            beat_cnt;
    logic [ID_WIDTH-1:0]   expected_id;

    logic                  rsp_i_valid;
    logic                  rsp_d_valid;
    logic                  rsp_last;
    logic                  rsp_err;
    logic [DATA_WIDTH-1:0] rsp_data;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifdef ARB_RR_EN
    logic last_d;   // 1 when the D-side was served most recently

    // With both requesting, serve whichever side was not served last.
    assign pick_d = d_req_valid && (!i_req_valid || !last_d);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_d <= 1'b1;
        end else if (accept) begin
            last_d <= pick_d;
        end
    end
`else
    assign pick_d = d_req_valid;
`endif

    assign accept = (state == IDLE) && (i_req_valid || d_req_valid);
    assign beat   = (state == DATA) && m_axi_rvalid;

    assign expected_id = {{(ID_WIDTH-1){1'b0}}, grant};

    // A beat is bad on a bad response, a foreign ID, an rlast that does not
    // line up with len, or a missing rlast on the beat that should be last.
    assign beat_err = (m_axi_rresp != 2'b00)
                   || (m_axi_rid != expected_id)
                   || (m_axi_rlast && (beat_cnt != m_axi_arlen))
                   || ((beat_cnt == m_axi_arlen) && !m_axi_rlast);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state;
        i_req_ready   = 1'b0;
        d_req_ready   = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        case (state)
            IDLE: begin
                i_req_ready = i_req_valid && !pick_d;
                d_req_ready = d_req_valid && pick_d;
                if (accept) begin
                    state_next = ADDR;
                end
            end
            ADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                m_axi_rready = 1'b1;
                // Only rlast closes the transaction; extra beats keep DATA.
                if (m_axi_rvalid && m_axi_rlast) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch, beat counter and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant        <= 1'b0;
            m_axi_araddr <= '0;
            m_axi_arlen  <= '0;
            m_axi_arsize <= '0;
            beat_cnt     <= '0;
            rsp_i_valid  <= 1'b0;
            rsp_d_valid  <= 1'b0;
            rsp_last     <= 1'b0;
            rsp_err      <= 1'b0;
            rsp_data     <= '0;
        end else begin
            if (accept) begin
                grant        <= pick_d;
                m_axi_araddr <= pick_d ? d_req_addr : i_req_addr;
                m_axi_arlen  <= pick_d ? d_req_len  : i_req_len;
                m_axi_arsize <= pick_d ? d_req_size : i_req_size;
                beat_cnt     <= '0;
            end
            rsp_i_valid <= beat && !grant;
            rsp_d_valid <= beat && grant;
            rsp_last    <= beat && m_axi_rlast;
            rsp_err     <= beat && beat_err;
            if (beat) begin
                rsp_data <= m_axi_rdata;
                beat_cnt <= beat_cnt + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign m_axi_arid    = expected_id;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0000;
    assign m_axi_arprot  = grant ? 3'b000 : 3'b100;

    // Data is shared; last/err are qualified so the idle side stays quiet.
    assign i_rsp_valid = rsp_i_valid;
    assign i_rsp_data  = rsp_data;
    assign i_rsp_last  = rsp_last && rsp_i_valid;
    assign i_rsp_err   = rsp_err && rsp_i_valid;
    assign d_rsp_valid = rsp_d_valid;
    assign d_rsp_data  = rsp_data;
    assign d_rsp_last  = rsp_last && rsp_d_valid;
    assign d_rsp_err   = rsp_err && rsp_d_valid;

endmodule
`default_nettype wire

// File: tb/tb_axi_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_read_arbiter
//  Description : Self-checking bench for axi_read_arbiter. Requesters and an
//                AXI slave are driven with randomized traffic; arbitration
//                and beat error flags are predicted from the arbiter's rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axi_read_arbiter;

    localparam int IDW = 13;
    localparam int AW  = 64;
    localparam int DW  = 64;

    logic           clk = 1'b0;
    logic           reset;
    logic           i_req_valid, i_req_ready, d_req_valid, d_req_ready;
    logic [AW-1:0]  i_req_addr, d_req_addr;
    logic [7:0]     i_req_len, d_req_len;
    logic [2:0]     i_req_size, d_req_size;
    logic           i_rsp_valid, i_rsp_last, i_rsp_err;
    logic           d_rsp_valid, d_rsp_last, d_rsp_err;
    logic [DW-1:0]  i_rsp_data, d_rsp_data;
    logic [IDW-1:0] m_axi_arid, m_axi_rid;
    logic [AW-1:0]  m_axi_araddr;
    logic [7:0]     m_axi_arlen;
    logic [2:0]     m_axi_arsize, m_axi_arprot;
    logic [1:0]     m_axi_arburst, m_axi_rresp;
    logic           m_axi_arlock, m_axi_arvalid, m_axi_arready;
    logic [3:0]     m_axi_arcache;
    logic [DW-1:0]  m_axi_rdata;
    logic           m_axi_rlast, m_axi_rvalid, m_axi_rready;

    axi_read_arbiter #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_req_len(i_req_len), .i_req_size(i_req_size),
        .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data), .i_rsp_last(i_rsp_last), .i_rsp_err(i_rsp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_req_len(d_req_len), .d_req_size(d_req_size),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_last(d_rsp_last), .d_rsp_err(d_rsp_err),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: history of which side was served (1 = D) since reset.
    bit served_d[$];

    function automatic bit model_pick_d(input bit vi, input bit vd);
        if (!vi) return 1'b1;
        if (!vd) return 1'b0;
`ifdef ARB_RR_EN
        // Nothing served since reset counts as D served last.
        if (served_d.size() == 0) return 1'b0;
        return !served_d[$];
`else
        return 1'b1;
`endif
    endfunction

    // Random requester activity while the arbiter is busy; must not be accepted.
    task automatic drive_noise();
        i_req_valid = 1'($urandom_range(0, 1));
        d_req_valid = 1'($urandom_range(0, 1));
        i_req_addr  = {$urandom(), $urandom()};
        d_req_addr  = {$urandom(), $urandom()};
    endtask

    task automatic check_busy_ready();
        check_val("busy_req_ready", 64'({i_req_ready, d_req_ready}), 64'd0);
    endtask

    task automatic apply_reset_check();
        reset         = 1'b0;
        i_req_valid   = 1'b0;
        d_req_valid   = 1'b0;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        #1;
        check_val("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
        check_val("rst_rready", 64'(m_axi_rready), 64'd0);
        check_val("rst_rsp_flags", 64'({i_rsp_valid, i_rsp_last, i_rsp_err, d_rsp_valid, d_rsp_last, d_rsp_err}), 64'd0);
        check_val("rst_i_rsp_data", i_rsp_data, 64'd0);
        check_val("rst_d_rsp_data", d_rsp_data, 64'd0);
        check_val("rst_araddr", m_axi_araddr, 64'd0);
        check_val("rst_arlen_size", 64'({m_axi_arlen, m_axi_arsize}), 64'd0);
        check_val("rst_arid", 64'(m_axi_arid), 64'd0);
        served_d.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            i_req_valid  = 1'b0;
            d_req_valid  = 1'b0;
            m_axi_rvalid = 1'($urandom_range(0, 1));
            m_axi_rlast  = 1'b1;
            #1;
            check_val("idle_ar_r", 64'({m_axi_arvalid, m_axi_rready}), 64'd0);
            @(negedge clk);
            check_val("idle_no_rsp", 64'({i_rsp_valid, d_rsp_valid}), 64'd0);
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
    endtask

    // One full transaction starting at a negedge in IDLE.
    // mode: 0 normal, 1 rresp error at beat eidx, 2 wrong rid,
    //       3 early rlast at beat eidx, 4 eidx extra beats past len.
    task automatic run_txn(input bit vi, input bit vd,
                           input logic [63:0] ia, input logic [7:0] il, input logic [2:0] isz,
                           input logic [63:0] da, input logic [7:0] dl, input logic [2:0] dsz,
                           input int mode, input int eidx, input int ar_delay, input int abort_after);
        bit             gd;
        logic [63:0]    ea;
        logic [7:0]     el;
        logic [2:0]     es;
        logic [IDW-1:0] eid;
        logic [DW-1:0]  edata;
        bit             eerr;
        int             nb;

        i_req_addr = ia; i_req_len = il; i_req_size = isz;
        d_req_addr = da; d_req_len = dl; d_req_size = dsz;
        i_req_valid = vi; d_req_valid = vd;
        #1;
        gd = model_pick_d(vi, vd);
        check_val("i_req_ready", 64'(i_req_ready), 64'(vi && !gd));
        check_val("d_req_ready", 64'(d_req_ready), 64'(vd && gd));
        @(negedge clk);
        served_d.push_back(gd);
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        ea  = gd ? da : ia;
        el  = gd ? dl : il;
        es  = gd ? dsz : isz;
        eid = gd ? IDW'(1) : IDW'(0);

        check_val("arvalid", 64'(m_axi_arvalid), 64'd1);
        check_val("arid", 64'(m_axi_arid), 64'(eid));
        check_val("araddr", m_axi_araddr, ea);
        check_val("arlen", 64'(m_axi_arlen), 64'(el));
        check_val("arsize", 64'(m_axi_arsize), 64'(es));
        check_val("arprot", 64'(m_axi_arprot), gd ? 64'd0 : 64'd4);
        check_val("ar_consts", 64'({m_axi_arburst, m_axi_arlock, m_axi_arcache}), 64'b01_0_0000);
        check_val("addr_rready", 64'(m_axi_rready), 64'd0);
        check_val("addr_no_rsp", 64'({i_rsp_valid, d_rsp_valid}), 64'd0);

        for (int c = 0; c < ar_delay; c++) begin
            drive_noise();
            m_axi_rvalid = 1'($urandom_range(0, 1));
            m_axi_rlast  = 1'b1;
            #1;
            check_busy_ready();
            @(negedge clk);
            check_val("ar_hold", 64'({m_axi_arvalid, m_axi_rready}), 64'b10);
            check_val("ar_stable", m_axi_araddr, ea);
            check_val("addr_no_rsp", 64'({i_rsp_valid, d_rsp_valid}), 64'd0);
        end
        m_axi_arready = 1'b1;
        drive_noise();
        #1;
        check_busy_ready();
        @(negedge clk);
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rlast   = 1'b0;
        check_val("data_ar_r", 64'({m_axi_arvalid, m_axi_rready}), 64'b01);
        check_val("data_no_rsp", 64'({i_rsp_valid, d_rsp_valid}), 64'd0);

        case (mode)
            3:       nb = eidx + 1;
            4:       nb = int'(el) + 1 + eidx;
            default: nb = int'(el) + 1;
        endcase

        for (int k = 0; k < nb; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                m_axi_rvalid = 1'b0;
                drive_noise();
                #1;
                check_busy_ready();
                check_val("gap_rready", 64'(m_axi_rready), 64'd1);
                @(negedge clk);
                check_val("gap_no_rsp", 64'({i_rsp_valid, d_rsp_valid}), 64'd0);
            end
            edata        = {$urandom(), $urandom()};
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = edata;
            m_axi_rid    = (mode == 2) ? (eid ^ IDW'(1)) : eid;
            m_axi_rresp  = (mode == 1 && k == eidx) ? 2'($urandom_range(1, 3)) : 2'b00;
            m_axi_rlast  = (k == nb - 1);
            drive_noise();
            #1;
            check_busy_ready();
            check_val("beat_rready", 64'(m_axi_rready), 64'd1);
            @(negedge clk);
            eerr = (m_axi_rresp != 2'b00) || (m_axi_rid != eid)
                || (m_axi_rlast && k != int'(el)) || (k == int'(el) && !m_axi_rlast);
            check_val("rsp_valid", 64'(gd ? d_rsp_valid : i_rsp_valid), 64'd1);
            check_val("other_rsp_valid", 64'(gd ? i_rsp_valid : d_rsp_valid), 64'd0);
            check_val("rsp_data", gd ? d_rsp_data : i_rsp_data, edata);
            check_val("rsp_last", 64'(gd ? d_rsp_last : i_rsp_last), 64'(k == nb - 1));
            check_val("rsp_err", 64'(gd ? d_rsp_err : i_rsp_err), 64'(eerr));
            if (k == abort_after) begin
                apply_reset_check();
                m_axi_rlast = 1'b0;
                return;
            end
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        i_req_valid  = 1'b0;
        d_req_valid  = 1'b0;
    endtask

    task automatic rand_txn();
        bit          vi, vd;
        int          mode, eidx;
        logic [7:0]  il, dl, el;
        vi = 1'($urandom_range(0, 1));
        vd = vi ? 1'($urandom_range(0, 1)) : 1'b1;
        il = 8'($urandom_range(0, 7));
        dl = 8'($urandom_range(0, 2));
        // Length of the side the model will grant decides legal error positions.
        el   = model_pick_d(vi, vd) ? dl : il;
        mode = $urandom_range(0, 4);
        eidx = 0;
        if (mode == 3 && el == 8'd0) mode = 0;
        if (mode == 1) eidx = $urandom_range(0, int'(el));
        if (mode == 3) eidx = $urandom_range(0, int'(el) - 1);
        if (mode == 4) eidx = $urandom_range(1, 2);
        run_txn(vi, vd, {$urandom(), $urandom()}, il, 3'($urandom_range(0, 3)),
                {$urandom(), $urandom()}, dl, 3'($urandom_range(0, 3)),
                mode, eidx, $urandom_range(0, 3), -1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        i_req_addr = '0; d_req_addr = '0;
        i_req_len = '0; d_req_len = '0; i_req_size = '0; d_req_size = '0;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
        @(negedge clk);
        apply_reset_check();

        // Single I-side fetch, arready after two cycles.
        run_txn(1'b1, 1'b0, 64'h1000, 8'd7, 3'd3, 64'h0, 8'd0, 3'd0, 0, 0, 2, -1);

        // Simultaneous requests from a fresh reset.
        apply_reset_check();
        for (int r = 0; r < 3; r++)
            run_txn(1'b1, 1'b1, 64'h2000 + 64'(r * 64), 8'd7, 3'd3,
                    64'h8000 + 64'(r * 8), 8'd0, 3'd3, 0, 0, 1, -1);

        // Error beats on the D-side.
        run_txn(1'b0, 1'b1, 64'h0, 8'd0, 3'd0, 64'h9000, 8'd0, 3'd3, 1, 0, 0, -1);
        run_txn(1'b0, 1'b1, 64'h0, 8'd0, 3'd0, 64'h9008, 8'd0, 3'd3, 2, 0, 1, -1);
        run_txn(1'b0, 1'b1, 64'h0, 8'd0, 3'd0, 64'h9010, 8'd3, 3'd3, 3, 1, 0, -1);
        run_txn(1'b0, 1'b1, 64'h0, 8'd0, 3'd0, 64'h9020, 8'd1, 3'd3, 4, 2, 0, -1);

        // D burst then an I request presented at the very next cycle.
        run_txn(1'b0, 1'b1, 64'h0, 8'd0, 3'd0, 64'hA000, 8'd3, 3'd3, 0, 0, 0, -1);
        run_txn(1'b1, 1'b0, 64'hB000, 8'd7, 3'd3, 64'h0, 8'd0, 3'd0, 0, 0, 0, -1);

        // Reset after the third beat of an 8-beat fetch, then a clean D read.
        run_txn(1'b1, 1'b0, 64'hC000, 8'd7, 3'd3, 64'h0, 8'd0, 3'd0, 0, 0, 1, 2);
        run_txn(1'b0, 1'b1, 64'h0, 8'd0, 3'd0, 64'hD000, 8'd0, 3'd3, 0, 0, 1, -1);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
            rand_txn();
        end
        idle_cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
